// File: rtl/addsub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addsub_pkg : shared types and helpers for the digit-serial add/sub   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package addsub_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Digit counter width; a 1-bit counter is kept even when NCYC is 1.
  function automatic int cnt_width(input int ncyc);
    return (ncyc > 2) ? $clog2(ncyc) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addsub_slice : combinational DIGIT-bit ripple full adder             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module addsub_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] w_c;

  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]     = x[i] ^ y[i] ^ w_c[i];
      w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end
  end

  assign cout     = w_c[DIGIT];
  assign c_msb_in = w_c[DIGIT-1];

endmodule
`default_nettype wire

// File: rtl/addsub_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addsub_serial : digit-serial two's-complement adder/subtractor       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cb,
  output logic             ovf,
  output logic             zero
);

  localparam int NCYC = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NCYC);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic             r_mode;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic             r_cb;
  logic             r_ovf;
  logic             r_zero;

  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [DIGIT-1:0] w_s;
  logic             w_cout;
  logic             w_c_msb_in;
  logic [WIDTH-1:0] w_acc_next;

  addsub_slice #(.DIGIT(DIGIT)) u_slice (
    .x        (r_a[DIGIT-1:0]),
    .y        (r_b[DIGIT-1:0]),
    .cin      (r_carry),
    .s        (w_s),
    .cout     (w_cout),
    .c_msb_in (w_c_msb_in)
  );

  // Partial result: new digit enters at the top, earlier digits move down.
  if (DIGIT == WIDTH) begin : g_single
    assign w_acc_next = w_s;
  end else begin : g_multi
    logic [WIDTH-DIGIT-1:0] r_acc;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_acc <= '0;
      else if (w_load) r_acc <= '0;
      else if (w_step) r_acc <= w_acc_next[WIDTH-1:DIGIT];
    end

    assign w_acc_next = {w_s, r_acc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_last       = (r_cnt == CW'(NCYC - 1));
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_mode   <= MODE_ADD;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_cb     <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        // Subtraction is a + ~b + 1: invert b here, inject the +1 as carry-in.
        r_a     <= a;
        r_b     <= (mode == MODE_ADD) ? b : ~b;
        r_mode  <= mode;
        r_carry <= (mode == MODE_SUB);
        r_cnt   <= '0;
      end else if (w_step) begin
        r_a     <= r_a >> DIGIT;
        r_b     <= r_b >> DIGIT;
        r_carry <= w_cout;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          r_result <= w_acc_next;
          r_cb     <= w_cout ^ r_mode;
          r_ovf    <= w_cout ^ w_c_msb_in;
          r_zero   <= (w_acc_next == '0);
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign busy   = (r_state == RUN);
  assign done   = r_done;
  assign result = r_result;
  assign cb     = r_cb;
  assign ovf    = r_ovf;
  assign zero   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_addsub_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_addsub_serial : scoreboard bench over three WIDTH/DIGIT configs   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_addsub_serial;

  logic clk;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   fin_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input int cfg, input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL cfg%0d %s: got %0h, required %0h (cycle %0d)", cfg, nm, act, req, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int W = (g == 2) ? 16 : 8;
    localparam int D = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    localparam int N = W / D;
    localparam int NOPS = 2000;

    typedef struct {
      logic [W-1:0] r;
      logic         cb;
      logic         ovf;
      logic         zero;
      longint       t;
    } exp_t;

    logic         rst, start, mode, busy, done, cb, ovf, zero;
    logic [W-1:0] a, b, result;
    exp_t         q[$];
    exp_t         held;

    addsub_serial #(.WIDTH(W), .DIGIT(D)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .mode   (mode),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cb     (cb),
      .ovf    (ovf),
      .zero   (zero)
    );

    // Reference: plain integer arithmetic, flags from unsigned/signed ranges.
    function automatic exp_t model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input longint t);
      exp_t   e;
      longint ux, uy, sx, sy, full, ss, smax;
      ux   = longint'(x);
      uy   = longint'(y);
      sx   = longint'($signed(x));
      sy   = longint'($signed(y));
      smax = (longint'(1) << (W - 1)) - 1;
      if (m) begin
        full = ux - uy;
        ss   = sx - sy;
        e.cb = (ux < uy);
      end else begin
        full = ux + uy;
        ss   = sx + sy;
        e.cb = full[W];
      end
      e.r    = full[W-1:0];
      e.ovf  = (ss > smax) || (ss < -smax - 1);
      e.zero = (e.r == '0);
      e.t    = t;
      return e;
    endfunction

    function automatic logic [W-1:0] rnd();
      case ($urandom_range(0, 5))
        0:       return '0;
        1:       return '1;
        2:       return {1'b1, {(W-1){1'b0}}};
        3:       return {1'b0, {(W-1){1'b1}}};
        default: return W'($urandom);
      endcase
    endfunction

    // Called on a falling edge; returns on the first falling edge of RUN.
    task automatic issue(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
      int guard = 0;
      while (busy && guard < 4 * N + 20) begin
        @(negedge clk);
        guard++;
      end
      chk(g, "idle_before_start", busy, 0);
      start = 1'b1;
      mode  = m;
      a     = x;
      b     = y;
      q.push_back(model(m, x, y, cyc + 1 + N));
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      mode  = 1'($urandom);
    endtask

    initial begin : drv
      int           guard;
      logic [W-1:0] x2, y2;
      rst   = 1'b1;
      start = 1'b0;
      mode  = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      chk(g, "rst_busy", busy, 0);
      chk(g, "rst_done", done, 0);
      chk(g, "rst_result", result, 0);
      chk(g, "rst_zero", zero, 1);
      chk(g, "rst_cb", cb, 0);
      chk(g, "rst_ovf", ovf, 0);
      #1 rst = 1'b0;

      if (g == 0) begin
        issue(1'b0, 'h7F, 'h01);
        issue(1'b1, 'h05, 'h07);
        issue(1'b1, 'h80, 'h01);
        issue(1'b1, 'h3C, 'h3C);
      end else if (g == 1) begin
        issue(1'b0, 'hFF, 'h01);
      end else begin
        issue(1'b1, '0, W'(1));
      end

      // start asserted during RUN with junk operands, then held into done.
      issue(1'b0, rnd(), rnd());
      start = 1'b1;
      guard = 0;
      while (!done && guard < 4 * N + 8) begin
        a    = W'($urandom);
        b    = W'($urandom);
        mode = 1'($urandom);
        @(negedge clk);
        guard++;
      end
      chk(g, "held_start_done_seen", done, 1);
      x2   = rnd();
      y2   = rnd();
      a    = x2;
      b    = y2;
      mode = 1'b1;
      q.push_back(model(1'b1, x2, y2, cyc + 1 + N));
      @(negedge clk);
      start = 1'b0;

      // Reset in the middle of an operation.
      issue(1'($urandom), rnd(), rnd());
      repeat ((N >= 5) ? 3 : 0) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk(g, "midrst_busy", busy, 0);
      chk(g, "midrst_done", done, 0);
      chk(g, "midrst_result", result, 0);
      chk(g, "midrst_zero", zero, 1);
      chk(g, "midrst_cb", cb, 0);
      chk(g, "midrst_ovf", ovf, 0);
      @(negedge clk);
      #1 rst = 1'b0;
      issue(1'b0, rnd(), rnd());

      for (int i = 0; i < NOPS; i++) begin
        if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        issue(1'($urandom), rnd(), rnd());
      end

      guard = 0;
      while (q.size() != 0 && guard < 8 * N + 40) begin
        @(negedge clk);
        guard++;
      end
      chk(g, "drain_empty", q.size(), 0);
      fin_cnt++;
    end

    initial begin : mon
      exp_t e;
      forever begin
        @(negedge clk);
        if (rst) begin
          q.delete();
          held.r    = '0;
          held.cb   = 1'b0;
          held.ovf  = 1'b0;
          held.zero = 1'b1;
          held.t    = 0;
        end else if (done) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL cfg%0d unexpected_done: got result %0h, required no done", g, result);
          end else begin
            e = q.pop_front();
            chk(g, "done_cycle", cyc, e.t);
            chk(g, "result", result, e.r);
            chk(g, "cb", cb, e.cb);
            chk(g, "ovf", ovf, e.ovf);
            chk(g, "zero", zero, e.zero);
            chk(g, "busy_at_done", busy, 0);
            held = e;
          end
        end else if (busy) begin
          chk(g, "hold_result", result, held.r);
          chk(g, "hold_cb", cb, held.cb);
          chk(g, "hold_ovf", ovf, held.ovf);
          chk(g, "hold_zero", zero, held.zero);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 90000 && fin_cnt < 3; i++) @(negedge clk);
    if (fin_cnt < 3) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: got %0d finished configs, required 3", fin_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
